// File: rtl/bomb_sfx_player.sv
// bomb_sfx_player: plays the bomb sample ROM once per trigger, scaled by a 3-bit volume.
// Ports:
//   i_clk, i_reset       clock, asynchronous active-high reset
//   i_vol[2:0]           volume, 0 = mute, 7 = 7/8 scale, latched per request
//   i_trigger            one-cycle pulse, starts or restarts playback
//   i_sample_req         one-cycle pulse, requests the next output sample
//   o_rom_addr           registered address to the synchronous sample ROM
//   i_rom_data[15:0]     signed ROM sample, valid one cycle after o_rom_addr
//   o_sample_out[15:0]   signed scaled sample, held between updates
//   o_sample_valid       one-cycle strobe when o_sample_out updates
//   o_busy               high while playing
//   o_done               one-cycle pulse with the last sample of a pass
module bomb_sfx_player #(
    parameter int SAMPLE_LEN = 12000,
    parameter int ADDR_W     = 14
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [2:0]        i_vol,
    input  logic              i_trigger,
    input  logic              i_sample_req,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic [15:0]       o_sample_out,
    output logic              o_sample_valid,
    output logic              o_busy,
    output logic              o_done
);
    typedef enum logic {S_IDLE, S_PLAY} state_t;
    state_t            r_state, w_state_n;
    logic [ADDR_W-1:0] w_addr_n;
    logic              r_s1_v, r_s1_play, r_s1_cnt, r_s1_last, r_s2_cnt;
    logic [2:0]        r_s1_vol;
    logic              w_accept;
    logic signed [19:0] w_prod;
    assign o_busy   = (r_state == S_PLAY);
    // a request is ignored while an earlier one is still in the pipeline
    assign w_accept = i_sample_req & ~r_s1_v & ~o_sample_valid;
    // volume is zero-extended so it is always a non-negative multiplier
    assign w_prod   = $signed({{4{i_rom_data[15]}}, i_rom_data}) * $signed({17'd0, r_s1_vol});
    // *_cnt flags mark samples that advance the current pass; a trigger
    // drops them so in-flight samples never count against the new pass
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s1_v         <= 1'b0;
            r_s1_play      <= 1'b0;
            r_s1_cnt       <= 1'b0;
            r_s1_last      <= 1'b0;
            r_s1_vol       <= '0;
            r_s2_cnt       <= 1'b0;
            o_sample_out   <= '0;
            o_sample_valid <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            r_s1_v   <= w_accept;
            r_s1_cnt <= w_accept & o_busy & ~i_trigger;
            if (w_accept) begin
                r_s1_vol  <= i_vol;
                r_s1_play <= o_busy;
                r_s1_last <= (o_rom_addr == ADDR_W'(SAMPLE_LEN - 1));
            end
            o_sample_valid <= r_s1_v;
            if (r_s1_v)
                o_sample_out <= r_s1_play ? 16'(w_prod >>> 3) : '0;
            r_s2_cnt <= r_s1_v & r_s1_cnt & ~i_trigger;
            o_done   <= r_s1_v & r_s1_cnt & r_s1_last & ~i_trigger;
        end
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            o_rom_addr <= '0;
        end else begin
            r_state    <= w_state_n;
            o_rom_addr <= w_addr_n;
        end
    end
    // the address advances in the cycle the counted sample is emitted
    always_comb begin
        w_state_n = r_state;
        w_addr_n  = o_rom_addr;
        if (i_trigger) begin
            w_state_n = S_PLAY;
            w_addr_n  = '0;
        end else if (r_s2_cnt) begin
            w_state_n = o_done ? S_IDLE : S_PLAY;
            w_addr_n  = o_done ? '0 : o_rom_addr + ADDR_W'(1);
        end
    end
endmodule

// File: tb/tb_bomb_sfx_player.sv
// tb_bomb_sfx_player: directed checks of bomb_sfx_player with a 4-sample ROM.
module tb_bomb_sfx_player;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  vol = '0;
    logic        trigger = 1'b0;
    logic        sample_req = 1'b0;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic [15:0] sample_out;
    logic        sample_valid, busy, done;
    logic [15:0] rom [0:15];
    int          n_chk = 0;
    int          n_bad = 0;

    bomb_sfx_player #(.SAMPLE_LEN(4), .ADDR_W(4)) dut (
        .i_clk(clk), .i_reset(reset), .i_vol(vol), .i_trigger(trigger),
        .i_sample_req(sample_req), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
        .o_sample_out(sample_out), .o_sample_valid(sample_valid),
        .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_trigger;
        trigger = 1'b1;
        step;
        trigger = 1'b0;
        check("trig_busy", 32'(busy), 32'd1);
        check("trig_addr", 32'(rom_addr), 32'd0);
    endtask

    // request at N; verify N+1 quiet, N+2 sample/done; optional trigger at N+2
    task automatic do_req(input string tag, input logic [15:0] exp, input logic exp_done, input logic trig2);
        sample_req = 1'b1;
        step;
        sample_req = 1'b0;
        check({tag, "_early"}, 32'(sample_valid), 32'd0);
        step;
        check({tag, "_valid"}, 32'(sample_valid), 32'd1);
        check({tag, "_out"}, 32'(sample_out), 32'(exp));
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        trigger = trig2;
        step;
        trigger = 1'b0;
        check({tag, "_vdrop"}, 32'(sample_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = '0;
        rom[0] = 16'h4000;
        rom[1] = 16'h8000;
        rom[2] = 16'hFFFF;
        rom[3] = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            vol = 3'($urandom);
            trigger = 1'($urandom);
            sample_req = 1'($urandom);
            step;
            check("rst_outs", {12'd0, rom_addr, sample_out}, 32'd0);
            check("rst_flags", {29'd0, sample_valid, busy, done}, 32'd0);
        end
        vol = '0;
        trigger = 1'b0;
        sample_req = 1'b0;
        reset = 1'b0;
        step;
        step;
        do_req("idle", 16'h0000, 1'b0, 1'b0);
        check("idle_busy", 32'(busy), 32'd0);

        vol = 3'd7;
        pulse_trigger;
        do_req("s0", 16'h3800, 1'b0, 1'b0);
        check("s0_addr", 32'(rom_addr), 32'd1);
        do_req("s1", 16'h9000, 1'b0, 1'b0);
        vol = 3'd1;
        do_req("s2", 16'hFFFF, 1'b0, 1'b0);
        vol = 3'd7;
        do_req("s3", 16'h0FED, 1'b1, 1'b0);
        check("end_busy", 32'(busy), 32'd0);
        check("end_addr", 32'(rom_addr), 32'd0);
        do_req("s4", 16'h0000, 1'b0, 1'b0);

        vol = 3'd0;
        pulse_trigger;
        do_req("mute0", 16'h0000, 1'b0, 1'b0);
        check("mute_busy", 32'(busy), 32'd1);
        do_req("mute1", 16'h0000, 1'b0, 1'b0);

        vol = 3'd7;
        pulse_trigger;
        sample_req = 1'b1;
        step;
        sample_req = 1'b0;
        vol = 3'd3;
        step;
        check("latch_old", 32'(sample_out), 32'h3800);
        step;
        do_req("latch_new", 16'hD000, 1'b0, 1'b0);

        vol = 3'd7;
        do_req("retrig", 16'hFFFF, 1'b0, 1'b1);
        check("retrig_addr", 32'(rom_addr), 32'd0);
        check("retrig_busy", 32'(busy), 32'd1);
        do_req("r0", 16'h3800, 1'b0, 1'b0);
        do_req("r1", 16'h9000, 1'b0, 1'b0);
        do_req("r2", 16'hFFFF, 1'b0, 1'b0);
        do_req("r3", 16'h0FED, 1'b1, 1'b0);
        check("r_busy", 32'(busy), 32'd0);

        pulse_trigger;
        do_req("pre", 16'h3800, 1'b0, 1'b0);
        sample_req = 1'b1;
        step;
        sample_req = 1'b0;
        reset = 1'b1;
        step;
        check("mid_valid", 32'(sample_valid), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_addr", 32'(rom_addr), 32'd0);
        reset = 1'b0;
        step;
        check("mid_valid2", 32'(sample_valid), 32'd0);
        check("mid_out", 32'(sample_out), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
